// File: rtl/datapath_pkg.sv
// Shared datapath constants and types used by the return-address stack.
package datapath_pkg;

  localparam int RAS_ADDR_W = 32;
  localparam int RAS_DEPTH  = 8;
  localparam int RAS_PTR_W  = $clog2(RAS_DEPTH);

  typedef logic [RAS_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ras_storage.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
module ras_storage #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_index,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_index,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; validity is tracked by the
  // owner's count, so clearing it would only cost a reset net to every bit.
  always_ff @(posedge clk) begin
    if (we) mem[wr_index] <= wr_data;
  end

  assign rd_data = mem[rd_index];

endmodule

// File: rtl/return_address_stack.sv
// Return-address stack for jal/jr prediction: circular buffer that overwrites the oldest entry when full.
// Optional RAS_STATS_EN adds saturating overflow/underflow event counters.
module return_address_stack
  import datapath_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int ADDR_W = RAS_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Push,
  input  logic [ADDR_W-1:0] PushAddress,
  input  logic              Pop,
  input  logic              Flush,
  output logic [ADDR_W-1:0] PopAddress,
  output logic              PopValid,
  output logic [ADDR_W-1:0] TopAddress,
  output logic              Empty,
  output logic              Full,
  output logic              Overflow,
  output logic              Underflow
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]       OverflowCount,
  output logic [15:0]       UnderflowCount
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  top_q;
  logic [PTR_W:0]    count_q;
  logic [ADDR_W-1:0] top_data;

  logic do_push, do_pop, pop_hit, replace, push_only, ovf_hit, udf_hit;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_index;

  assign Empty = (count_q == '0);
  assign Full  = (count_q == DEPTH_CNT);

  // NOTE: every signal driven here gets a value on every path, so no latches form.
  always_comb begin
    do_push   = Push & ~Flush;
    do_pop    = Pop & ~Flush;
    pop_hit   = do_pop & ~Empty;
    replace   = do_push & pop_hit;
    push_only = do_push & ~pop_hit;
    ovf_hit   = push_only & Full;
    udf_hit   = do_pop & Empty;
    wr_en     = (push_only | replace) & ~Reset;
    wr_index  = replace ? top_q : top_q + 1'b1;
  end

  ras_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk      (Clk),
    .we       (wr_en),
    .wr_index (wr_index),
    .wr_data  (PushAddress),
    .rd_index (top_q),
    .rd_data  (top_data)
  );

  // Stale storage must never leak out of an empty stack.
  assign TopAddress = Empty ? '0 : top_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      top_q      <= '0;
      count_q    <= '0;
      PopAddress <= '0;
      PopValid   <= 1'b0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
    end else if (Flush) begin
      top_q     <= '0;
      count_q   <= '0;
      PopValid  <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      PopValid  <= pop_hit;
      Overflow  <= ovf_hit;
      Underflow <= udf_hit;
      if (pop_hit)      PopAddress <= top_data;
      else if (udf_hit) PopAddress <= '0;

      if (push_only) begin
        top_q <= top_q + 1'b1;
        if (!Full) count_q <= count_q + 1'b1;
      end else if (pop_hit && !replace) begin
        top_q   <= top_q - 1'b1;
        count_q <= count_q - 1'b1;
      end
    end
  end

`ifdef RAS_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OverflowCount  <= '0;
      UnderflowCount <= '0;
    end else begin
      if (ovf_hit && OverflowCount != 16'hFFFF)  OverflowCount  <= OverflowCount + 16'd1;
      if (udf_hit && UnderflowCount != 16'hFFFF) UnderflowCount <= UnderflowCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_return_address_stack.sv
// Scoreboard bench for return_address_stack: directed ops queue expected pulses, a monitor checks them.
module tb_return_address_stack;

  typedef enum logic [1:0] {EV_NONE, EV_POP, EV_OVF, EV_UDF} ev_kind_t;
  typedef struct packed {
    logic        pop_valid;
    logic [31:0] pop_address;
    logic        overflow;
    logic        underflow;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset, push, pop, flush;
  logic [31:0] push_address;
  logic [31:0] pop_address, top_address;
  logic        pop_valid, empty, full, overflow, underflow;
`ifdef RAS_STATS_EN
  logic [15:0] overflow_count, underflow_count;
`endif

  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];

  return_address_stack #(.DEPTH(8), .ADDR_W(32)) dut (
    .Clk         (clk),
    .Reset       (reset),
    .Push        (push),
    .PushAddress (push_address),
    .Pop         (pop),
    .Flush       (flush),
    .PopAddress  (pop_address),
    .PopValid    (pop_valid),
    .TopAddress  (top_address),
    .Empty       (empty),
    .Full        (full),
    .Overflow    (overflow),
    .Underflow   (underflow)
`ifdef RAS_STATS_EN
    ,
    .OverflowCount  (overflow_count),
    .UnderflowCount (underflow_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the pulse it must cause next cycle.
  task automatic op(input logic p, input logic [31:0] a, input logic q, input logic f,
                    input ev_kind_t kind, input logic [31:0] exp_addr);
    ev_t e;
    @(negedge clk);
    push = p; push_address = a; pop = q; flush = f;
    e = '0;
    case (kind)
      EV_POP: begin e.pop_valid = 1'b1; e.pop_address = exp_addr; end
      EV_OVF: e.overflow = 1'b1;
      EV_UDF: e.underflow = 1'b1;
      default: ;
    endcase
    if (kind != EV_NONE) exp_q.push_back(e);
  endtask

  task automatic check_state(input string tag, input logic e, input logic fl, input logic [31:0] top);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    check({tag, ".empty"}, 64'(empty), 64'(e));
    check({tag, ".full"}, 64'(full), 64'(fl));
    check({tag, ".top"}, 64'(top_address), 64'(top));
  endtask

  // Monitor: every presented pulse must match the oldest queued expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (pop_valid || overflow || underflow) begin
        check("event_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pop_valid", 64'(pop_valid), 64'(e.pop_valid));
          check("overflow", 64'(overflow), 64'(e.overflow));
          check("underflow", 64'(underflow), 64'(e.underflow));
          if (e.pop_valid || e.underflow)
            check("pop_address", 64'(pop_address), 64'(e.pop_address));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; push_address = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst.pop_valid", 64'(pop_valid), 64'd0);
    check("rst.overflow", 64'(overflow), 64'd0);
    check("rst.underflow", 64'(underflow), 64'd0);
    check("rst.pop_address", 64'(pop_address), 64'd0);
    check_state("rst", 1'b1, 1'b0, 32'h0);

    // Pop on empty
    op(0, 0, 1, 0, EV_UDF, 32'h0);
    check_state("udf0", 1'b1, 1'b0, 32'h0);

    // Basic push/pop ordering
    op(1, 32'h0040_0004, 0, 0, EV_NONE, 0);
    op(1, 32'h0040_0010, 0, 0, EV_NONE, 0);
    check_state("two", 1'b0, 1'b0, 32'h0040_0010);
    op(0, 0, 1, 0, EV_POP, 32'h0040_0010);
    op(0, 0, 1, 0, EV_POP, 32'h0040_0004);
    check_state("two_done", 1'b1, 1'b0, 32'h0);

    // Fill, overflow, wrap, drain
    for (int i = 1; i <= 8; i++) op(1, 32'(i * 'h100), 0, 0, EV_NONE, 0);
    check_state("full8", 1'b0, 1'b1, 32'h800);
    op(1, 32'h900, 0, 0, EV_OVF, 0);
    check_state("full9", 1'b0, 1'b1, 32'h900);
    for (int i = 9; i >= 2; i--) op(0, 0, 1, 0, EV_POP, 32'(i * 'h100));
    op(0, 0, 1, 0, EV_UDF, 32'h0);
    check_state("drained", 1'b1, 1'b0, 32'h0);

    // Simultaneous push+pop replaces in place
    op(1, 32'h1000, 0, 0, EV_NONE, 0);
    op(1, 32'h2000, 1, 0, EV_POP, 32'h1000);
    check_state("replace", 1'b0, 1'b0, 32'h2000);
    op(0, 0, 1, 0, EV_POP, 32'h2000);
    check_state("replace_done", 1'b1, 1'b0, 32'h0);

    // Push+pop on empty: push plus underflow
    op(1, 32'h44, 1, 0, EV_UDF, 32'h0);
    check_state("pp_empty", 1'b0, 1'b0, 32'h44);
    op(0, 0, 1, 0, EV_POP, 32'h44);

    // Flush beats a same-cycle push
    op(1, 32'hA, 0, 0, EV_NONE, 0);
    op(1, 32'hB, 0, 0, EV_NONE, 0);
    op(1, 32'hC, 0, 0, EV_NONE, 0);
    op(1, 32'hD, 0, 1, EV_NONE, 0);
    check_state("flush", 1'b1, 1'b0, 32'h0);
    op(0, 0, 1, 0, EV_UDF, 32'h0);

    // Reset mid-operation suppresses the pop and empties the stack
    op(1, 32'h55, 0, 0, EV_NONE, 0);
    @(negedge clk);
    push = 1'b0; pop = 1'b1; reset = 1'b1;
    @(negedge clk);
    pop = 1'b0; reset = 1'b0;
    check_state("mid_reset", 1'b1, 1'b0, 32'h0);

`ifdef RAS_STATS_EN
    for (int i = 1; i <= 10; i++)
      op(1, 32'(i * 'h10), 0, 0, (i > 8) ? EV_OVF : EV_NONE, 0);
    for (int i = 10; i >= 3; i--) op(0, 0, 1, 0, EV_POP, 32'(i * 'h10));
    for (int i = 0; i < 3; i++) op(0, 0, 1, 0, EV_UDF, 32'h0);
    check_state("stats", 1'b1, 1'b0, 32'h0);
    check("ovf_count", 64'(overflow_count), 64'd2);
    check("udf_count", 64'(underflow_count), 64'd3);
    op(0, 0, 0, 1, EV_NONE, 0);
    check_state("stats_flush", 1'b1, 1'b0, 32'h0);
    check("ovf_count_flush", 64'(overflow_count), 64'd2);
    check("udf_count_flush", 64'(underflow_count), 64'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("ovf_count_rst", 64'(overflow_count), 64'd0);
    check("udf_count_rst", 64'(underflow_count), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("events_outstanding", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
